// File: rtl/nes_pkg.sv
// ---------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the CPU-side blocks of the console.
//   dma_state_t  : OAM DMA sequencer states
//   OAMDMA_ADDR  : CPU address whose write starts a sprite DMA
//   OAMDATA_ADDR : PPU OAM data register, destination of every DMA write
// ---------------------------------------------------------------------------
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_if.sv
// ---------------------------------------------------------------------------
// oam_dma_if
// Bus bundle between the OAM DMA engine and the integrating CPU-side level.
//   cpu_addr/cpu_rw/cpu_data_i : snooped CPU bus (rw: 1 = read, 0 = write)
//   bus_data_i                 : read data returned by the CPU-side memory map
//   cpu_halt                   : stalls the CPU while the DMA owns the bus
//   dma_active                 : bus-mux select, dma_* replaces the CPU bus
//   dma_addr/dma_rw/dma_data_o : DMA bus cycle (rw: 1 = read)
//   done                       : one-cycle pulse on the final OAM write
// Modports: master = the DMA engine, slave = the integrating level.
// ---------------------------------------------------------------------------
interface oam_dma_if;

    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_i;
    logic [7:0]  bus_data_i;
    logic        cpu_halt;
    logic        dma_active;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_data_o;
    logic        done;

    modport master (
        input  cpu_addr, cpu_rw, cpu_data_i, bus_data_i,
        output cpu_halt, dma_active, dma_addr, dma_rw, dma_data_o, done
    );

    modport slave (
        output cpu_addr, cpu_rw, cpu_data_i, bus_data_i,
        input  cpu_halt, dma_active, dma_addr, dma_rw, dma_data_o, done
    );

endinterface

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
// Sprite-memory DMA engine. Snoops CPU writes; a write of page P to
// DMA_REG_ADDR halts the CPU, takes the bus and copies P00..PFF into the
// PPU OAM by writing each byte to OAM_DATA_ADDR.
// Ports:
//   clk : CPU-rate clock
//   rst : synchronous active-low reset
//   bus : oam_dma_if.master (CPU snoop inputs, DMA bus outputs)
// All outputs decode registered state only; no input-to-output path.
// ---------------------------------------------------------------------------
module oam_dma
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = OAMDMA_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = OAMDATA_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    oam_dma_if.master  bus
);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_HALT  = HALT;
    localparam logic [2:0] ST_ALIGN = ALIGN;
    localparam logic [2:0] ST_READ  = READ;
    localparam logic [2:0] ST_WRITE = WRITE;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       put;        // 0 = get (read) cycle, 1 = put (write) cycle
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] byte_reg;
    logic       trigger;

    // Writes to the DMA register while a transfer runs are ignored.
    assign trigger = !bus.cpu_rw && (bus.cpu_addr == DMA_REG_ADDR) && (state == ST_IDLE);

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (trigger) state_nxt = ST_HALT;
            // Reads must land on get cycles: the cycle after HALT is a get
            // cycle only when HALT itself is a put cycle.
            ST_HALT:  state_nxt = put ? ST_READ : ST_ALIGN;
            ST_ALIGN: state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (idx == 8'hFF) ? ST_IDLE : ST_READ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // Reset wins over a simultaneous trigger and abandons any transfer.
            put      <= 1'b0;
            state    <= ST_IDLE;
            page     <= 8'h00;
            idx      <= 8'h00;
            byte_reg <= 8'h00;
        end else begin
            put   <= ~put;
            state <= state_nxt;
            if (trigger) begin
                page <= bus.cpu_data_i;
                idx  <= 8'h00;
            end
            if (state == ST_READ) begin
                byte_reg <= bus.bus_data_i;
            end
            // 8-bit wrap on purpose: idx never carries into page.
            if (state == ST_WRITE) begin
                idx <= idx + 8'd1;
            end
        end
    end

    always_comb begin
        bus.cpu_halt   = 1'b0;
        bus.dma_active = 1'b0;
        bus.dma_addr   = 16'h0000;
        bus.dma_rw     = 1'b1;
        bus.dma_data_o = 8'h00;
        bus.done       = 1'b0;
        case (state)
            ST_HALT, ST_ALIGN: begin
                // Dummy read while the CPU settles; its data is discarded.
                bus.cpu_halt   = 1'b1;
                bus.dma_active = 1'b1;
                bus.dma_addr   = {page, 8'h00};
            end
            ST_READ: begin
                bus.cpu_halt   = 1'b1;
                bus.dma_active = 1'b1;
                bus.dma_addr   = {page, idx};
            end
            ST_WRITE: begin
                bus.cpu_halt   = 1'b1;
                bus.dma_active = 1'b1;
                bus.dma_addr   = OAM_DATA_ADDR;
                bus.dma_rw     = 1'b0;
                bus.dma_data_o = byte_reg;
                bus.done       = (idx == 8'hFF);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
// Self-checking bench for oam_dma. A memory model answers reads with
// addr[7:0] ^ 8'h5A. Each trigger pushes the expected read/write pairs and
// the expected halt length; a negedge monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_oam_dma;
    import nes_pkg::*;

    typedef struct {
        logic [15:0] rd_addr;
        logic [7:0]  data;
        logic        last;
    } exp_t;

    logic clk;
    logic rst;
    oam_dma_if bus ();

    oam_dma dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: combinational read data from the DMA address.
    assign bus.bus_data_i = bus.dma_addr[7:0] ^ 8'h5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_writes = 0;
    exp_t exp_q[$];
    int   len_q[$];

    // Independent model of the get/put parity.
    logic tb_put;
    always @(posedge clk) tb_put <= !rst ? 1'b0 : !tb_put;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Monitor
    logic [15:0] prev_addr = 16'h0000;
    logic        prev_put  = 1'b0;
    logic        prev_halt = 1'b0;
    int          halt_cnt  = 0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            len_q.delete();
            halt_cnt  = 0;
            prev_halt = 1'b0;
        end else begin
            if (bus.cpu_halt) begin
                halt_cnt++;
            end else if (prev_halt) begin
                check("halt_len_expected", 32'(len_q.size() != 0), 1);
                if (len_q.size() != 0) check("halt_len", halt_cnt, len_q.pop_front());
                check("active_after", bus.dma_active, 0);
                halt_cnt = 0;
            end
            if (bus.dma_active && !bus.dma_rw) begin
                exp_t e;
                n_writes++;
                check("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wr_addr", bus.dma_addr, 16'h2004);
                    check("wr_data", bus.dma_data_o, e.data);
                    check("rd_addr", prev_addr, e.rd_addr);
                    check("rd_on_get", prev_put, 0);
                    check("done", bus.done, e.last);
                end
            end else begin
                check("done_stray", bus.done, 0);
            end
            prev_halt = bus.cpu_halt;
        end
        prev_addr = bus.dma_addr;
        prev_put  = tb_put;
    end

    task automatic bus_idle();
        bus.cpu_addr   = 16'h0000;
        bus.cpu_rw     = 1'b1;
        bus.cpu_data_i = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_halt"},   bus.cpu_halt,   0);
        check({tag, "_active"}, bus.dma_active, 0);
        check({tag, "_addr"},   bus.dma_addr,   16'h0000);
        check({tag, "_rw"},     bus.dma_rw,     1);
        check({tag, "_data"},   bus.dma_data_o, 8'h00);
        check({tag, "_done"},   bus.done,       0);
    endtask

    // Issue a trigger write on a cycle chosen so HALT does (align=1) or does
    // not (align=0) need the extra ALIGN cycle, and record expectations.
    task automatic trigger(input logic [7:0] page, input logic align);
        @(posedge clk); #1;
        if (tb_put != align) begin
            @(posedge clk); #1;
        end
        bus.cpu_addr   = 16'h4014;
        bus.cpu_rw     = 1'b0;
        bus.cpu_data_i = page;
        len_q.push_back(align ? 514 : 513);
        for (int i = 0; i < 256; i++) begin
            exp_t e;
            e.rd_addr = {page, 8'(i)};
            e.data    = 8'(i) ^ 8'h5A;
            e.last    = (i == 255);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus_idle();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.cpu_halt) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain", exp_q.size(), 0);
        check("released", bus.dma_active, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // No ALIGN: HALT on a put cycle, 513 halted cycles, reads 0200..02FF.
        trigger(8'h02, 1'b0);
        wait_done(1000);

        // ALIGN path: 514 halted cycles, reads still on get cycles.
        trigger(8'h02, 1'b1);
        wait_done(1000);

        // Page FF: last read at FFFF, idx wraps, back to IDLE.
        trigger(8'hFF, 1'b0);
        wait_done(1000);

        // Non-triggers while idle: read of 4014 and write to 4015.
        @(posedge clk); #1;
        bus.cpu_addr = 16'h4014; bus.cpu_rw = 1'b1; bus.cpu_data_i = 8'h33;
        @(posedge clk); #1;
        bus.cpu_addr = 16'h4015; bus.cpu_rw = 1'b0; bus.cpu_data_i = 8'h44;
        @(posedge clk); #1;
        bus_idle();
        repeat (4) begin
            @(negedge clk);
            check("no_trigger_halt", bus.cpu_halt, 0);
        end

        // Write to 4014 during a transfer: no restart, page unchanged.
        trigger(8'h05, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        bus.cpu_addr = 16'h4014; bus.cpu_rw = 1'b0; bus.cpu_data_i = 8'h77;
        @(posedge clk); #1;
        bus_idle();
        wait_done(1000);

        // Reset beats a simultaneous trigger.
        @(posedge clk); #1;
        rst = 1'b0;
        bus.cpu_addr = 16'h4014; bus.cpu_rw = 1'b0; bus.cpu_data_i = 8'h10;
        @(posedge clk); #1;
        rst = 1'b1;
        bus_idle();
        repeat (3) begin
            @(negedge clk);
            check("rst_prio_halt", bus.cpu_halt, 0);
        end

        // Reset after the 100th WRITE abandons the transfer.
        base = n_writes;
        trigger(8'h01, 1'b0);
        for (int n = 0; n < 400 && n_writes < base + 100; n++) begin
            @(posedge clk); #1;
        end
        check("writes_before_reset", n_writes - base, 100);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");

        // Fresh transfer after the abort starts at 0300.
        trigger(8'h03, 1'b0);
        wait_done(1000);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite-memory DMA engine on the CPU-side bus. It snoops CPU writes. A write of page value P to the DMA register does three things:
- halts the CPU;
- takes ownership of the CPU bus;
- copies the 256 bytes at P00–PFF into the PPU's OAM by writing each byte to the OAM data register.

It sits between the CPU and the CPU-side memory map/PPU chip-select logic, clocked by `clk_cpu`.

## Interface
Parameters:
- `DMA_REG_ADDR`, 16'h4014: CPU address that triggers a transfer.
- `OAM_DATA_ADDR`, 16'h2004: destination address for every DMA write.

Ports:
- `clk` in 1: CPU-rate clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-low.
- `cpu_addr` in 16: CPU address bus, snooped.
- `cpu_rw` in 1: CPU read/write. 1 = read, 0 = write.
- `cpu_data_i` in 8: CPU write data. Provides the page number on trigger.
- `bus_data_i` in 8: read data from the CPU-side memory map. Combinational, valid by the end of the read cycle.
- `cpu_halt` out 1: high while the DMA owns the bus. The CPU stalls.
- `dma_active` out 1: bus-mux select. When high, `dma_*` replaces the CPU's address, rw and data.
- `dma_addr` out 16: DMA bus address.
- `dma_rw` out 1: DMA read/write. 1 = read.
- `dma_data_o` out 8: DMA write data.
- `done` out 1: one-cycle pulse on the final OAM write.

## Operation
- **Parity flop `put`.** Cleared by reset, toggles every clock. `put=0` is a get cycle (reads), `put=1` is a put cycle (writes).
- **Trigger.** `cpu_rw==0 && cpu_addr==DMA_REG_ADDR && state==IDLE`. On that edge:
  - latch `page <= cpu_data_i`;
  - clear the 8-bit `idx`;
  - go to HALT.
- **Triggers outside IDLE** are ignored.
- **State transitions:**
  - IDLE → HALT on trigger.
  - HALT → READ if the next cycle is a get cycle, else HALT → ALIGN.
  - ALIGN → READ.
  - READ → WRITE.
  - WRITE → READ while `idx != 8'hFF`. When `idx == 8'hFF`, WRITE → IDLE.
- **`idx` update.** `idx` increments on leaving WRITE and wraps 8'hFF → 8'h00. It never carries into `page`.
- **Outputs per state:**
  - IDLE: `dma_active=0`, `cpu_halt=0`, `dma_rw=1`.
  - HALT / ALIGN: `dma_active=1`, `cpu_halt=1`, `dma_rw=1`, `dma_addr={page,8'h00}`. This is a dummy read; its data is discarded.
  - READ: `dma_addr={page,idx}`, `dma_rw=1`. `bus_data_i` is latched into the `byte` register at the end of the cycle.
  - WRITE: `dma_addr=OAM_DATA_ADDR`, `dma_rw=0`, `dma_data_o=byte`. `done=1` when `idx==8'hFF`.
- **Output encoding.** All outputs are decoded from registered state/`page`/`idx`/`byte`. No combinational path from inputs to outputs.

## Timing
- **Trigger to halt.** The trigger is sampled at the edge ending the CPU write cycle. `cpu_halt` rises in the following cycle (the HALT state).
- **Transfer length,** HALT through the final WRITE: 513 cycles without ALIGN, 514 with ALIGN.
- **Release.** The CPU regains the bus in the cycle after the final WRITE, with `dma_active=0`.
- **Read-to-write pairing.** A READ at `{P,i}` is followed by a WRITE of that byte in the very next cycle.
- **Reset values:** `cpu_halt=0`, `dma_active=0`, `dma_addr=16'h0000`, `dma_rw=1`, `dma_data_o=8'h00`, `done=0`. Internally: `put=0`, state IDLE, `page=0`, `idx=0`, `byte=0`.
- **Reset mid-transfer.** The next cycle shows reset values and the transfer is abandoned, not resumed. OAM keeps the partial contents.
- **Reset priority.** Reset beats a simultaneous trigger.
- **Page 8'hFF.** Last read address is 16'hFFFF, with no overflow.

## Structure
- **Shared package `nes_pkg`:**
  - `dma_state_t` enum: IDLE, HALT, ALIGN, READ, WRITE;
  - address constants `OAMDMA_ADDR=16'h4014`, `OAMDATA_ADDR=16'h2004`. These are the parameter defaults.
- **No sub-module.** The block is a single FSM plus the parity flop and the `page`/`idx`/`byte` registers.
- **Integration.** The top-level bus mux (CPU vs. DMA, selected by `dma_active`) lives in the integrating level, not in this block. The PPU chip-select then sees `16'h2004` writes exactly as it sees CPU writes.

## Test plan
- **Trigger on a get cycle, no ALIGN.** Reset, then CPU writes 8'h02 to 16'h4014 so that HALT falls on a put cycle. Expect:
  - `cpu_halt` high for 513 cycles;
  - first READ at 16'h0200, last READ at 16'h02FF;
  - `done` pulses once;
  - `dma_active` low the cycle after.
- **ALIGN path.** Same trigger shifted by one cycle. Expect one ALIGN cycle, 514 halted cycles, and the first READ on a cycle with `put=0`.
- **Data integrity.** Memory model returns `addr[7:0]^8'h5A`. Expect 256 writes to 16'h2004 with data 8'h5A, 8'h5B, …, 8'hA5 in order.
- **Page wrap.** Trigger with page 8'hFF. Expect:
  - last READ at 16'hFFFF;
  - `idx` wraps to 0;
  - no read at 16'h0000;
  - return to IDLE.
- **Reset mid-transfer.** Pull `rst` low after the 100th WRITE. Expect:
  - the next cycle shows all outputs at reset values;
  - a new trigger with 8'h03 restarts with the first READ at 16'h0300.
- **Non-triggers.** A CPU read of 16'h4014, a write to 16'h4015, and a write to 16'h4014 during an active transfer must cause no new transfer or restart, and no change to `page`.
